bcd_scan_controller: RTL and testbench

- Sequential replacement for the combinational divide-based number-to-display formatter.
- One shared shift-add-3 (double-dabble) engine converts four 10-bit FSM result slots to 3-digit BCD, one slot at a time, on request.
- Publishes a 48-bit display word atomically, so the seven-segment driver never sees a half-updated frame.
- Sits between the game FSM and the display driver.

---
 rtl/bcd_scan_controller.sv | 140 ++++++++++++++
 tb/tb_bcd_scan_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_controller.sv
// Sequential binary-to-BCD display formatter: one shared double-dabble engine scans four slots.
// Optional macro BCD_SCAN_AUTO_REFRESH_EN makes the controller rescan continuously instead of on start.
module bcd_scan_controller #(
  parameter int SAT_VALUE = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  num1,
  input  logic [9:0]  num2,
  input  logic [9:0]  num3,
  input  logic [9:0]  num4,
  input  logic [3:0]  valid,
  input  logic        start,
  output logic [47:0] numbers,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

  localparam logic [9:0] SAT_CLAMP = 10'(SAT_VALUE);

  state_t            state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic [3:0][9:0]   snap_num_q, snap_num_d;
  logic [3:0]        snap_valid_q, snap_valid_d;
  logic [9:0]        bin_q, bin_d;
  logic [2:0][3:0]   bcd_q, bcd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0][11:0]  shadow_q, shadow_d;
  logic [47:0]       numbers_q, numbers_d;

  logic              scan_go;
  logic [2:0][3:0]   bcd_adj;
  logic [21:0]       shift_src;
  logic [9:0]        slot_value;

`ifdef BCD_SCAN_AUTO_REFRESH_EN
  assign scan_go = 1'b1;
`else
  assign scan_go = start;
`endif

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bcd_adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
    end
    shift_src  = {bcd_adj, bin_q};
    slot_value = (snap_num_q[slot_q] > SAT_CLAMP) ? SAT_CLAMP : snap_num_q[slot_q];
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    snap_num_d   = snap_num_q;
    snap_valid_d = snap_valid_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    numbers_d    = numbers_q;

    case (state_q)
      IDLE: begin
        if (scan_go) begin
          snap_num_d   = {num4, num3, num2, num1};
          snap_valid_d = valid;
          slot_d       = 2'd0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (snap_valid_q[slot_q]) begin
          bin_d   = slot_value;
          bcd_d   = '0;
          cnt_d   = 4'd10;
          state_d = SHIFT;
        end else begin
          shadow_d[slot_q] = 12'hFFF;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {shift_src[20:0], 1'b0};
        cnt_d          = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = STORE;
        end
      end
      STORE: begin
        shadow_d[slot_q] = bcd_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Both a finished STORE and a blank LOAD close the slot; the last slot publishes the frame whole.
    if ((state_q == STORE) || ((state_q == LOAD) && !snap_valid_q[slot_q])) begin
      if (slot_q == 2'd3) begin
        state_d   = DONE;
        numbers_d = shadow_d;
      end else begin
        slot_d  = slot_q + 2'd1;
        state_d = LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= 2'd0;
      snap_num_q   <= '0;
      snap_valid_q <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '1;
      numbers_q    <= '1;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      snap_num_q   <= snap_num_d;
      snap_valid_q <= snap_valid_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      numbers_q    <= numbers_d;
    end
  end

  assign numbers = numbers_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Self-checking bench for bcd_scan_controller (default build): directed and random scans
// checked against a decimal-arithmetic reference model of the displayed frame and its timing.
module tb_bcd_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  num1, num2, num3, num4;
  logic [3:0]  valid;
  logic        start;
  logic [47:0] numbers;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [47:0] shown;

  bcd_scan_controller #(.SAT_VALUE(999)) dut (
    .clk(clk), .rst(rst),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .valid(valid), .start(start),
    .numbers(numbers), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference: decimal digits of the clamped value, or a blank slot.
  function automatic logic [11:0] slotWord(input int v, input bit ok);
    int c;
    if (!ok) return 12'hFFF;
    c = (v > 999) ? 999 : v;
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [47:0] frameWord(input int a, input int b, input int c, input int d,
                                            input logic [3:0] v);
    return {slotWord(d, v[3]), slotWord(c, v[2]), slotWord(b, v[1]), slotWord(a, v[0])};
  endfunction

  function automatic int scanCycles(input logic [3:0] v);
    int n = 1;
    for (int i = 0; i < 4; i++) n += v[i] ? 12 : 1;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a scan from IDLE and checks latency, result, stability and the return to IDLE.
  task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                               input logic [9:0] d, input logic [3:0] v, input bit start_in_done,
                               input string tag);
    int cyc;
    logic [47:0] expw;
    logic [47:0] prev;
    expw = frameWord(int'(a), int'(b), int'(c), int'(d), v);
    num1 = a; num2 = b; num3 = c; num4 = d; valid = v; start = 1'b1;
    tick();
    start = 1'b0;
    num1 = 10'($urandom); num2 = 10'($urandom); num3 = 10'($urandom); num4 = 10'($urandom);
    valid = 4'($urandom);
    cyc = 1;
    checkOutput({tag, "_busy_rise"}, 64'(busy), 64'd1);
    prev = numbers;
    while (done !== 1'b1 && cyc < 120) begin
      prev = numbers;
      tick();
      cyc++;
    end
    checkOutput({tag, "_done_cycle"}, 64'(cyc), 64'(scanCycles(v)));
    checkOutput({tag, "_hold_before"}, 64'(prev), 64'(shown));
    checkOutput({tag, "_numbers"}, 64'(numbers), 64'(expw));
    shown = expw;
    if (start_in_done) start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    tick();
    checkOutput({tag, "_stay_idle"}, {14'd0, busy, done, numbers}, {16'd0, shown});
  endtask

  initial begin
    int cyc;
    int done_cnt;
    bit any_busy;
    rst = 1'b1; start = 1'b0; valid = 4'd0;
    num1 = '0; num2 = '0; num3 = '0; num4 = '0;
    shown = 48'hFFFF_FFFF_FFFF;

    repeat (3) tick();
    checkOutput("reset_state", {14'd0, busy, done, numbers}, {16'd0, 48'hFFFF_FFFF_FFFF});
    rst = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || numbers !== 48'hFFFF_FFFF_FFFF) any_busy = 1'b1;
    end
    checkOutput("idle_hold_100", 64'(any_busy), 64'd0);

    applyStimulus(10'd24, 10'd5, 10'd100, 10'd999, 4'b1111, 1'b0, "all_valid");
    applyStimulus(10'd1023, 10'd7, 10'd512, 10'd0, 4'b0101, 1'b1, "clamp_mixed");

    // Snapshot must survive input changes, and a start while busy must be dropped.
    num1 = 10'd37; valid = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 4) begin tick(); cyc++; end
    num1 = 10'd88; start = 1'b1;
    tick(); cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 120) begin tick(); cyc++; end
    checkOutput("snap_done_cycle", 64'(cyc), 64'd16);
    checkOutput("snap_numbers", 64'(numbers), 64'(frameWord(37, 0, 0, 0, 4'b0001)));
    shown = frameWord(37, 0, 0, 0, 4'b0001);
    done_cnt = 0; any_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) any_busy = 1'b1;
    end
    checkOutput("snap_no_rescan", {63'(done_cnt), any_busy}, 64'd0);

    // Reset mid-scan discards the scan and blanks the display.
    num1 = 10'd1; num2 = 10'd2; num3 = 10'd3; num4 = 10'd4; valid = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 1; i < 6; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset_state", {14'd0, busy, done, numbers}, {16'd0, 48'hFFFF_FFFF_FFFF});
    shown = 48'hFFFF_FFFF_FFFF;
    tick();
    checkOutput("midreset_no_done", {62'(done_cnt), busy, done}, 64'd0);
    applyStimulus(10'd321, 10'd654, 10'd987, 10'd10, 4'b1111, 1'b0, "after_reset");

    applyStimulus(10'd5, 10'd6, 10'd7, 10'd8, 4'b0000, 1'b1, "all_blank");

    // Reset and start together: reset wins.
    num1 = 10'd9; valid = 4'b1111; start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    shown = 48'hFFFF_FFFF_FFFF;
    checkOutput("rst_wins", {14'd0, busy, done, numbers}, {16'd0, 48'hFFFF_FFFF_FFFF});
    tick();
    checkOutput("rst_wins_idle", 64'(busy), 64'd0);

    for (int k = 0; k < 10; k++) begin
      applyStimulus(10'($urandom), 10'($urandom), 10'($urandom_range(1023, 990)),
                    10'($urandom_range(15, 0)), 4'($urandom), 1'($urandom), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
